dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: max cycles a request waits for i_DMEM_ready before timeout (range 1..255).
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- i_MEM_ctrl_MemRead  in  1  pipeline load request.
- i_MEM_ctrl_MemWrite  in  1  pipeline store request.
- i_MEM_data_Addr  in  32  pipeline byte address.
- i_MEM_data_WData  in  32  pipeline store data.
- o_MEM_data_RData  out  32  pipeline load data.
- o_MEM_ctrl_Stall  out  1  freeze pipeline while access is incomplete.
- i_DBG_req  in  1  debug-port request, held until o_DBG_gnt.
- i_DBG_we  in  1  debug write (1) / read (0).
- i_DBG_addr  in  32  debug address.
- i_DBG_wdata  in  32  debug write data.
- o_DBG_gnt  out  1  one-cycle debug accept pulse.
- o_DBG_done  out  1  one-cycle debug completion pulse.
- o_DBG_rdata  out  32  debug read data.
- o_DMEM_req  out  1  memory request, held until ready.
- o_DMEM_we  out  1  memory write enable.
- o_DMEM_addr  out  32  memory address.
- o_DMEM_wdata  out  32  memory write data.
- i_DMEM_ready  in  1  memory completion; rdata valid same cycle.
- i_DMEM_rdata  in  32  memory read data.
- o_ERR_timeout  out  1  sticky timeout flag.

Function
REQ-003 SHALL implement FSM states IDLE, P_BUSY, P_DONE, D_BUSY.
REQ-004 Pipeline request (preq) SHALL be MemRead|MemWrite; MemWrite=1 SHALL make the access a write regardless of MemRead.
REQ-005 o_MEM_ctrl_Stall SHALL be combinational: preq AND state!=P_DONE.
REQ-006 IDLE: if preq and i_DBG_req both pending, SHALL grant per round-robin flag last_dbg (last_dbg=1 -> pipeline, else debug); single requester granted directly.
REQ-007 Pipeline grant: IDLE->P_BUSY; SHALL latch addr, wdata, we from MEM inputs; o_DMEM_req=1 from next cycle; last_dbg<=0.
REQ-008 Debug grant: IDLE->D_BUSY; o_DBG_gnt=1 in the grant cycle; SHALL latch debug addr/wdata/we; last_dbg<=1.
REQ-009 o_DMEM_req/we/addr/wdata SHALL be registered and stable throughout P_BUSY/D_BUSY; o_DMEM_req=0 in IDLE/P_DONE.
REQ-010 P_BUSY with i_DMEM_ready=1: SHALL capture i_DMEM_rdata (reads only) into o_MEM_data_RData, go to P_DONE; minimum pipeline access = 3 cycles (grant, busy, done).
REQ-011 P_DONE: Stall=0 for exactly one cycle; RData held; next state IDLE unconditionally.
REQ-012 D_BUSY with i_DMEM_ready=1: SHALL capture rdata into o_DBG_rdata (reads only), pulse o_DBG_done next cycle, go to IDLE.
REQ-013 o_MEM_data_RData and o_DBG_rdata SHALL hold last value until next completing read of same port.
REQ-014 8-bit wait counter SHALL clear on entry to a BUSY state and increment each BUSY cycle without ready.
REQ-015 Counter reaching WAIT_MAX without ready: SHALL drop o_DMEM_req, set o_ERR_timeout=1 (sticky until reset), complete the access as if ready with read data 32'h0.
REQ-016 i_DMEM_ready in IDLE/P_DONE SHALL be ignored.
REQ-017 Change of MEM inputs during P_BUSY SHALL NOT affect the latched access.

Reset
REQ-018 nrst=0 SHALL asynchronously force: state IDLE, last_dbg=0, counter 0, o_DMEM_req/we=0, o_DMEM_addr/wdata=0, o_MEM_data_RData=0, o_DBG_rdata=0, o_DBG_gnt=0, o_DBG_done=0, o_ERR_timeout=0.
REQ-019 Reset mid-access SHALL abandon it with no completion pulse; first request after release is treated as new.

Verification
REQ-020 Pipeline read addr 0x100, ready after 2 busy cycles with rdata 0xCAFE0001 -> Stall high 4 cycles, RData=0xCAFE0001 in P_DONE, Stall low.
REQ-021 Pipeline write addr 0x40 data 0x12345678 (Read also 1) -> o_DMEM_we=1, addr 0x40, wdata 0x12345678; no RData update.
REQ-022 preq and i_DBG_req together twice in a row -> debug, then pipeline, then debug; gnt pulse per debug grant.
REQ-023 No ready for WAIT_MAX=15 cycles -> req dropped, o_ERR_timeout=1 persists, RData=0, Stall released.
REQ-024 nrst low in D_BUSY -> all outputs reset values, no o_DBG_done pulse.
REQ-025 Debug read 0x200 returning 0xA5A5A5A5 with MEM idle -> gnt, then done one cycle, o_DBG_rdata=0xA5A5A5A5, Stall stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the pipeline MEM stage
// and a debug port. Round-robin arbitration, registered memory request,
// per-access wait counter with a sticky timeout flag.
//
// Handshake semantics used on every port of this block:
// - Memory side: o_DMEM_req is a registered valid that stays high, with
//   we/addr/wdata stable, until the cycle in which i_DMEM_ready is sampled high.
//   That cycle is the completion, and i_DMEM_rdata is valid in the same cycle.
//   i_DMEM_ready is ignored whenever o_DMEM_req is low.
// - Debug side: i_DBG_req is held until o_DBG_gnt is seen.
//   o_DBG_gnt is registered and pulses in the first D_BUSY cycle.
//   o_DBG_done pulses one cycle after the memory completes.
// - Pipeline side: o_MEM_ctrl_Stall holds the pipeline while a request is
//   pending. It drops for the single P_DONE cycle, and RData is valid then.
module dmem_arbiter #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_MEM_ctrl_MemRead,
  input  logic        i_MEM_ctrl_MemWrite,
  input  logic [31:0] i_MEM_data_Addr,
  input  logic [31:0] i_MEM_data_WData,
  output logic [31:0] o_MEM_data_RData,
  output logic        o_MEM_ctrl_Stall,
  input  logic        i_DBG_req,
  input  logic        i_DBG_we,
  input  logic [31:0] i_DBG_addr,
  input  logic [31:0] i_DBG_wdata,
  output logic        o_DBG_gnt,
  output logic        o_DBG_done,
  output logic [31:0] o_DBG_rdata,
  output logic        o_DMEM_req,
  output logic        o_DMEM_we,
  output logic [31:0] o_DMEM_addr,
  output logic [31:0] o_DMEM_wdata,
  input  logic        i_DMEM_ready,
  input  logic [31:0] i_DMEM_rdata,
  output logic        o_ERR_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    P_BUSY = 2'd1,
    P_DONE = 2'd2,
    D_BUSY = 2'd3
  } state_t;

  // Last busy cycle index that may still see ready before timing out.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state;
  state_t     state_nxt;
  logic       last_dbg;
  logic [7:0] wait_cnt;
  logic       preq;
  logic       pgrant;
  logic       dgrant;
  logic       busy;
  logic       timeout;
  logic       finish;
  logic [31:0] rdata_fin;

  assign preq      = i_MEM_ctrl_MemRead | i_MEM_ctrl_MemWrite;
  assign busy      = (state == P_BUSY) || (state == D_BUSY);
  assign timeout   = busy && !i_DMEM_ready && (wait_cnt == WAIT_LAST);
  assign finish    = busy && (i_DMEM_ready || timeout);
  // A timed-out access completes as a read of zero.
  assign rdata_fin = i_DMEM_ready ? i_DMEM_rdata : 32'h0;

  // The pipeline is frozen whenever it asks, except in the completion cycle.
  assign o_MEM_ctrl_Stall = preq && (state != P_DONE);

  // Arbitration: a lone requester wins, and a tie goes to whoever did not win last.
  always_comb begin
    pgrant = 1'b0;
    dgrant = 1'b0;
    if (state == IDLE) begin
      if (preq && i_DBG_req) begin
        if (last_dbg) pgrant = 1'b1;
        else          dgrant = 1'b1;
      end else if (preq) begin
        pgrant = 1'b1;
      end else if (i_DBG_req) begin
        dgrant = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pgrant)      state_nxt = P_BUSY;
        else if (dgrant) state_nxt = D_BUSY;
      end
      P_BUSY: if (finish) state_nxt = P_DONE;
      P_DONE: state_nxt = IDLE;
      D_BUSY: if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Memory request and wait counter.
  // The access is latched at grant, so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_DMEM_req   <= 1'b0;
      o_DMEM_we    <= 1'b0;
      o_DMEM_addr  <= 32'h0;
      o_DMEM_wdata <= 32'h0;
      wait_cnt     <= 8'h0;
      last_dbg     <= 1'b0;
    end else if (pgrant) begin
      o_DMEM_req   <= 1'b1;
      o_DMEM_we    <= i_MEM_ctrl_MemWrite;
      o_DMEM_addr  <= i_MEM_data_Addr;
      o_DMEM_wdata <= i_MEM_data_WData;
      wait_cnt     <= 8'h0;
      last_dbg     <= 1'b0;
    end else if (dgrant) begin
      o_DMEM_req   <= 1'b1;
      o_DMEM_we    <= i_DBG_we;
      o_DMEM_addr  <= i_DBG_addr;
      o_DMEM_wdata <= i_DBG_wdata;
      wait_cnt     <= 8'h0;
      last_dbg     <= 1'b1;
    end else if (finish) begin
      o_DMEM_req   <= 1'b0;
      o_DMEM_we    <= 1'b0;
    end else if (busy) begin
      wait_cnt     <= wait_cnt + 8'd1;
    end
  end

  // Read-data capture. Each port's register holds until its own next completing read.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_MEM_data_RData <= 32'h0;
      o_DBG_rdata      <= 32'h0;
    end else if (finish && !o_DMEM_we) begin
      if (state == P_BUSY) o_MEM_data_RData <= rdata_fin;
      if (state == D_BUSY) o_DBG_rdata      <= rdata_fin;
    end
  end

  // Debug pulses and the sticky timeout flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_DBG_gnt     <= 1'b0;
      o_DBG_done    <= 1'b0;
      o_ERR_timeout <= 1'b0;
    end else begin
      o_DBG_gnt  <= dgrant;
      o_DBG_done <= (state == D_BUSY) && finish;
      if (timeout) o_ERR_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table of single transactions plus hand-written
// sequences for arbitration, ready-while-idle and reset mid-access.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_stall;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_done;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        err_timeout;

  dmem_arbiter #(.WAIT_MAX(15)) dut (
    .clk                 (clk),
    .nrst                (nrst),
    .i_MEM_ctrl_MemRead  (mem_read),
    .i_MEM_ctrl_MemWrite (mem_write),
    .i_MEM_data_Addr     (mem_addr),
    .i_MEM_data_WData    (mem_wdata),
    .o_MEM_data_RData    (mem_rdata),
    .o_MEM_ctrl_Stall    (mem_stall),
    .i_DBG_req           (dbg_req),
    .i_DBG_we            (dbg_we),
    .i_DBG_addr          (dbg_addr),
    .i_DBG_wdata         (dbg_wdata),
    .o_DBG_gnt           (dbg_gnt),
    .o_DBG_done          (dbg_done),
    .o_DBG_rdata         (dbg_rdata),
    .o_DMEM_req          (dmem_req),
    .o_DMEM_we           (dmem_we),
    .o_DMEM_addr         (dmem_addr),
    .o_DMEM_wdata        (dmem_wdata),
    .i_DMEM_ready        (dmem_ready),
    .i_DMEM_rdata        (dmem_rdata),
    .o_ERR_timeout       (err_timeout)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dmem_req"},   {31'h0, dmem_req},    32'h0);
    chk({tag, "_dmem_we"},    {31'h0, dmem_we},     32'h0);
    chk({tag, "_dmem_addr"},  dmem_addr,            32'h0);
    chk({tag, "_dmem_wdata"}, dmem_wdata,           32'h0);
    chk({tag, "_mem_rdata"},  mem_rdata,            32'h0);
    chk({tag, "_dbg_rdata"},  dbg_rdata,            32'h0);
    chk({tag, "_dbg_gnt"},    {31'h0, dbg_gnt},     32'h0);
    chk({tag, "_dbg_done"},   {31'h0, dbg_done},    32'h0);
    chk({tag, "_err"},        {31'h0, err_timeout}, 32'h0);
  endtask

  // ---------------- vector table ----------------
  // lat = busy cycles without ready before the responder answers (99 = never).
  // exp_cyc = stall-high cycles for pipeline, done-pulse cycle index for debug.
  typedef struct {
    bit          dbg;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    bit          exp_we;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(bit dbg, bit rd, bit wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, int lat, int exp_cyc, logic [31:0] exp_rdata,
                              bit exp_we, bit exp_err);
    vec_t v;
    v.dbg = dbg; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.lat = lat; v.exp_cyc = exp_cyc; v.exp_rdata = exp_rdata; v.exp_we = exp_we;
    v.exp_err = exp_err;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_pipe(input vec_t v, input string tag);
    int stall_cnt = 0;
    int busy = 0;
    bit done = 0;
    bit stable = 1;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; mem_addr = v.addr; mem_wdata = v.wdata;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (!mem_stall) begin
        done = 1;
      end else begin
        stall_cnt++;
        if (dmem_req) begin
          if (busy == 0) begin
            chk({tag, "_we"},    {31'h0, dmem_we}, {31'h0, v.exp_we});
            chk({tag, "_addr"},  dmem_addr, v.addr);
            chk({tag, "_wdata"}, dmem_wdata, v.wdata);
            // Scramble the pipeline inputs; the latched access must not move.
            mem_addr = ~v.addr; mem_wdata = ~v.wdata;
          end else if (dmem_addr !== v.addr || dmem_wdata !== v.wdata ||
                       dmem_we !== v.exp_we) begin
            stable = 0;
          end
          dmem_ready = (busy == v.lat);
          dmem_rdata = v.rdata;
          busy++;
        end else begin
          dmem_ready = 0;
        end
        @(negedge clk); #1;
      end
    end
    dmem_ready = 0;
    chk({tag, "_finished"},   {31'h0, done}, 32'h1);
    chk({tag, "_stall_cyc"},  stall_cnt, v.exp_cyc);
    chk({tag, "_stable"},     {31'h0, stable}, 32'h1);
    chk({tag, "_req_done"},   {31'h0, dmem_req}, 32'h0);
    chk({tag, "_rdata"},      mem_rdata, v.exp_rdata);
    chk({tag, "_err"},        {31'h0, err_timeout}, {31'h0, v.exp_err});
    mem_read = 0; mem_write = 0; mem_addr = 32'h0; mem_wdata = 32'h0;
    @(negedge clk); #1;
    chk({tag, "_rdata_hold"}, mem_rdata, v.exp_rdata);
  endtask

  task automatic run_dbg(input vec_t v, input string tag);
    int stall_cnt = 0;
    int gnt_cnt = 0;
    int gnt_at = -1;
    int done_at = -1;
    int busy = 0;
    bit done = 0;
    bit stable = 1;
    @(negedge clk);
    dbg_req = 1; dbg_we = v.wr; dbg_addr = v.addr; dbg_wdata = v.wdata;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (mem_stall) stall_cnt++;
      if (dbg_gnt) begin
        gnt_cnt++; gnt_at = c; dbg_req = 0;
      end
      if (dbg_done) begin
        done = 1; done_at = c;
      end else begin
        if (dmem_req) begin
          if (dmem_addr !== v.addr || dmem_wdata !== v.wdata || dmem_we !== v.exp_we)
            stable = 0;
          dmem_ready = (busy == v.lat);
          dmem_rdata = v.rdata;
          busy++;
        end else begin
          dmem_ready = 0;
        end
        @(negedge clk); #1;
      end
    end
    dmem_ready = 0;
    chk({tag, "_done_at"},  done_at, v.exp_cyc);
    chk({tag, "_gnt_at"},   gnt_at, 1);
    chk({tag, "_gnt_cnt"},  gnt_cnt, 1);
    chk({tag, "_no_stall"}, stall_cnt, 0);
    chk({tag, "_access"},   {31'h0, stable}, 32'h1);
    chk({tag, "_rdata"},    dbg_rdata, v.exp_rdata);
    chk({tag, "_err"},      {31'h0, err_timeout}, {31'h0, v.exp_err});
    @(negedge clk); #1;
    chk({tag, "_done_pulse"}, {31'h0, dbg_done}, 32'h0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] e;
    logic        prev_req;
    int          gnts;
    int          seen;
    int          done_cnt;

    vecs[0] = mk(0, 1, 0, 32'h100, 32'h0,        32'hCAFE0001, 2,  4,  32'hCAFE0001, 0, 0);
    vecs[1] = mk(0, 1, 1, 32'h40,  32'h12345678, 32'hDEADBEEF, 0,  2,  32'hCAFE0001, 1, 0);
    vecs[2] = mk(1, 0, 0, 32'h200, 32'h0,        32'hA5A5A5A5, 1,  3,  32'hA5A5A5A5, 0, 0);
    vecs[3] = mk(0, 1, 0, 32'h104, 32'h0,        32'h11112222, 0,  2,  32'h11112222, 0, 0);
    vecs[4] = mk(1, 0, 1, 32'h300, 32'h55,       32'h77,       3,  5,  32'hA5A5A5A5, 1, 0);
    vecs[5] = mk(0, 0, 1, 32'h44,  32'hFFFF0000, 32'h33,       5,  7,  32'h11112222, 1, 0);
    vecs[6] = mk(0, 1, 0, 32'h108, 32'h0,        32'h5555AAAA, 99, 16, 32'h0,        0, 1);
    vecs[7] = mk(1, 0, 0, 32'h20C, 32'h0,        32'h99,       99, 16, 32'h0,        0, 1);

    nrst = 0;
    mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    dmem_ready = 0; dmem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("reset");
    chk("reset_stall", {31'h0, mem_stall}, 32'h0);
    @(negedge clk);
    nrst = 1;

    // Arbitration: both requesters held high -> debug, pipeline, debug.
    @(negedge clk);
    exp_q = {32'h600, 32'h500, 32'h600};
    mem_read = 1; mem_addr = 32'h500;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h600;
    dmem_ready = 1; dmem_rdata = 32'h0BADF00D;
    #1;
    prev_req = 0; gnts = 0; seen = 0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (dbg_gnt) gnts++;
      if (dmem_req && !prev_req) begin
        e = exp_q.pop_front();
        chk("arb_order", dmem_addr, e);
        chk("arb_gnt_with_dbg", {31'h0, dbg_gnt}, {31'h0, (e == 32'h600)});
        seen++;
      end
      prev_req = dmem_req;
      if (exp_q.size() > 0) begin
        @(negedge clk); #1;
      end
    end
    chk("arb_all_grants", seen, 3);
    chk("arb_gnt_count", gnts, 2);
    mem_read = 0; dbg_req = 0;
    repeat (3) @(negedge clk);
    dmem_ready = 0;

    // Table of single transactions.
    foreach (vecs[i]) begin
      if (vecs[i].dbg) run_dbg(vecs[i], $sformatf("v%0d", i));
      else             run_pipe(vecs[i], $sformatf("v%0d", i));
    end

    // Ready with no request pending must be ignored.
    @(negedge clk);
    dmem_ready = 1; dmem_rdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_ready_mem_rdata", mem_rdata, 32'h0);
    chk("idle_ready_dbg_rdata", dbg_rdata, 32'h0);
    chk("idle_ready_done", {31'h0, dbg_done}, 32'h0);
    chk("idle_ready_req", {31'h0, dmem_req}, 32'h0);
    chk("err_sticky", {31'h0, err_timeout}, 32'h1);
    dmem_ready = 0;

    // Reset while in D_BUSY: access is abandoned without a done pulse.
    @(negedge clk);
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h700;
    @(negedge clk); #1;
    chk("rst_dbusy_gnt", {31'h0, dbg_gnt}, 32'h1);
    chk("rst_dbusy_req", {31'h0, dmem_req}, 32'h1);
    dbg_req = 0;
    nrst = 0;
    #1;
    chk_reset_vals("rst_dbusy");
    @(negedge clk);
    dmem_ready = 1; dmem_rdata = 32'h12121212;
    @(negedge clk);
    nrst = 1;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (dbg_done) done_cnt++;
    end
    chk("rst_no_done", done_cnt, 0);
    chk("rst_dbg_rdata", dbg_rdata, 32'h0);
    dmem_ready = 0;

    // First request after reset runs as a fresh access.
    run_pipe(mk(0, 1, 0, 32'h10, 32'h0, 32'h600DF00D, 1, 3, 32'h600DF00D, 0, 0), "post_rst");

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule
